// File: rtl/tomasulo_pkg.sv
// tomasulo_pkg: shared ROB/CDB sizing, FU indices and ROB age helper
package tomasulo_pkg;
    localparam int ROB_DEPTH = 8;
    localparam int TAG_W = 3;
    localparam int DATA_W = 16;
    localparam int NUM_FU = 3;
    localparam int FU_ADD = 0;
    localparam int FU_MUL = 1;
    localparam int FU_BCH = 2;

    typedef enum logic {EMPTY, FULL} slot_state_t;

    function automatic logic [TAG_W-1:0] age(input logic [TAG_W-1:0] tag, input logic [TAG_W-1:0] head);
        return tag - head;
    endfunction
endpackage

// File: rtl/cdb_hold_slot.sv
// cdb_hold_slot: one-entry result buffer per FU with ready generation and flush kill
module cdb_hold_slot
    import tomasulo_pkg::*;
(
    input  logic              clk1,
    input  logic              rst,
    input  logic              valid,
    output logic              ready,
    input  logic [TAG_W-1:0]  tag_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic [TAG_W-1:0]  rob_head,
    input  logic              flush,
    input  logic [TAG_W-1:0]  flush_tag,
    input  logic              grant,
    output logic              live,
    output logic [TAG_W-1:0]  slot_age,
    output logic [TAG_W-1:0]  tag,
    output logic [DATA_W-1:0] data
);
    slot_state_t state;
    logic [TAG_W-1:0] fa;
    logic in_kill, accept;

    always_comb begin
        fa = age(flush_tag, rob_head);
        slot_age = age(tag, rob_head);
        in_kill = flush && (age(tag_in, rob_head) > fa);
        live = (state == FULL) && !(flush && (slot_age > fa));
        ready = (state == EMPTY) || grant;
        accept = valid && ready;
    end

    // a killed incoming offer still handshakes but is never stored
    always_ff @(posedge clk1 or posedge rst)
        if (rst) begin
            state <= EMPTY;
            tag <= '0;
            data <= '0;
        end else if (accept && !in_kill) begin
            state <= FULL;
            tag <= tag_in;
            data <= data_in;
        end else if (grant || (state == FULL && !live)) begin
            state <= EMPTY;
        end
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: buffers one result per FU and broadcasts the oldest (by ROB age) on the CDB each cycle
module cdb_arbiter #(
    parameter int NUM_FU    = tomasulo_pkg::NUM_FU,
    parameter int ROB_DEPTH = tomasulo_pkg::ROB_DEPTH,
    parameter int TAG_W     = tomasulo_pkg::TAG_W,
    parameter int DATA_W    = tomasulo_pkg::DATA_W
) (
    input  logic                     clk1,
    input  logic                     rst,
    input  logic [NUM_FU-1:0]        fu_valid,
    output logic [NUM_FU-1:0]        fu_ready,
    input  logic [NUM_FU*TAG_W-1:0]  fu_tag,
    input  logic [NUM_FU*DATA_W-1:0] fu_data,
    input  logic [TAG_W-1:0]         rob_head,
    input  logic                     flush,
    input  logic [TAG_W-1:0]         flush_tag,
    output logic                     cdb_valid,
    output logic [TAG_W-1:0]         cdb_tag,
    output logic [DATA_W-1:0]        cdb_data
);
    logic [NUM_FU-1:0] live, grant;
    logic [NUM_FU*TAG_W-1:0] ages, tags;
    logic [NUM_FU*DATA_W-1:0] datas;
    logic grant_any;
    logic [TAG_W-1:0] best_age, best_tag;
    logic [DATA_W-1:0] best_data;

    if (ROB_DEPTH != (1 << TAG_W)) begin : g_bad_depth
        $error("ROB_DEPTH must equal 2**TAG_W");
    end

    genvar g;
    for (g = 0; g < NUM_FU; g++) begin : g_slot
        cdb_hold_slot u_slot (
            .clk1     (clk1),
            .rst      (rst),
            .valid    (fu_valid[g]),
            .ready    (fu_ready[g]),
            .tag_in   (fu_tag[g*TAG_W +: TAG_W]),
            .data_in  (fu_data[g*DATA_W +: DATA_W]),
            .rob_head (rob_head),
            .flush    (flush),
            .flush_tag(flush_tag),
            .grant    (grant[g]),
            .live     (live[g]),
            .slot_age (ages[g*TAG_W +: TAG_W]),
            .tag      (tags[g*TAG_W +: TAG_W]),
            .data     (datas[g*DATA_W +: DATA_W])
        );
    end

    // strict less-than keeps the lowest FU index on an age tie
    always_comb begin
        grant = '0;
        grant_any = 1'b0;
        best_age = '0;
        best_tag = '0;
        best_data = '0;
        for (int i = 0; i < NUM_FU; i++)
            if (live[i] && (!grant_any || ages[i*TAG_W +: TAG_W] < best_age)) begin
                grant = '0;
                grant[i] = 1'b1;
                grant_any = 1'b1;
                best_age = ages[i*TAG_W +: TAG_W];
                best_tag = tags[i*TAG_W +: TAG_W];
                best_data = datas[i*DATA_W +: DATA_W];
            end
    end

    always_ff @(posedge clk1 or posedge rst)
        if (rst) begin
            cdb_valid <= 1'b0;
            cdb_tag <= '0;
            cdb_data <= '0;
        end else begin
            cdb_valid <= grant_any;
            if (grant_any) begin
                cdb_tag <= best_tag;
                cdb_data <= best_data;
            end
        end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed scoreboard bench for cdb_arbiter
module tb_cdb_arbiter;
    import tomasulo_pkg::*;

    logic clk1 = 1'b0;
    logic rst = 1'b0;
    logic [2:0] fu_valid = '0;
    logic [2:0] fu_ready;
    logic [8:0] fu_tag = '0;
    logic [47:0] fu_data = '0;
    logic [2:0] rob_head = '0;
    logic flush = 1'b0;
    logic [2:0] flush_tag = '0;
    logic cdb_valid;
    logic [2:0] cdb_tag;
    logic [15:0] cdb_data;

    int tests = 0;
    int fails = 0;
    logic [18:0] sb[$];

    cdb_arbiter dut (
        .clk1(clk1), .rst(rst), .fu_valid(fu_valid), .fu_ready(fu_ready),
        .fu_tag(fu_tag), .fu_data(fu_data), .rob_head(rob_head),
        .flush(flush), .flush_tag(flush_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data)
    );

    always #5 clk1 = ~clk1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk1);
        #1;
    endtask

    task automatic offer(input int fu, input logic [2:0] tag, input logic [15:0] data);
        fu_valid[fu] = 1'b1;
        fu_tag[fu*3 +: 3] = tag;
        fu_data[fu*16 +: 16] = data;
    endtask

    task automatic expect_cdb(input logic [2:0] tag, input logic [15:0] data);
        sb.push_back({tag, data});
    endtask

    task automatic drain(input string name, input int cycles);
        for (int i = 0; i < cycles; i++) step();
        chk(name, sb.size(), 0);
    endtask

    always @(negedge clk1)
        if (!rst && cdb_valid) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL cdb_unexpected: got tag %0d data %0h expected no broadcast", cdb_tag, cdb_data);
            end else begin
                chk("cdb_result", {13'd0, cdb_tag, cdb_data}, {13'd0, sb.pop_front()});
            end
        end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        #1 rst = 1'b1;
        #2;
        chk("rst_valid", cdb_valid, 0);
        chk("rst_tag", cdb_tag, 0);
        chk("rst_data", cdb_data, 0);
        rst = 1'b0;
        #1;
        chk("rst_ready", fu_ready, 3'b111);
        step();

        // single offer
        rob_head = 3'd0;
        offer(FU_ADD, 3'd2, 16'h1234);
        expect_cdb(3'd2, 16'h1234);
        step();
        fu_valid = '0;
        chk("single_not_yet", cdb_valid, 0);
        step();
        chk("single_valid", cdb_valid, 1);
        chk("single_tag", cdb_tag, 2);
        step();
        chk("single_idle", cdb_valid, 0);
        drain("single_drain", 2);

        // age with wrap, head=6
        rob_head = 3'd6;
        offer(FU_ADD, 3'd1, 16'hA001);
        offer(FU_MUL, 3'd7, 16'hA007);
        offer(FU_BCH, 3'd6, 16'hA006);
        expect_cdb(3'd6, 16'hA006);
        expect_cdb(3'd7, 16'hA007);
        expect_cdb(3'd1, 16'hA001);
        step();
        fu_valid = '0;
        drain("wrap_drain", 6);

        // backpressure on add
        rob_head = 3'd0;
        offer(FU_BCH, 3'd1, 16'hB001);
        offer(FU_ADD, 3'd4, 16'hB004);
        expect_cdb(3'd1, 16'hB001);
        expect_cdb(3'd4, 16'hB004);
        expect_cdb(3'd5, 16'hB005);
        step();
        fu_valid = '0;
        offer(FU_ADD, 3'd5, 16'hB005);
        #1 chk("bp_stall_ready", fu_ready[0], 0);
        step();
        chk("bp_release_ready", fu_ready[0], 1);
        step();
        fu_valid = '0;
        chk("bp_tag4", cdb_tag, 4);
        step();
        chk("bp_tag5", cdb_tag, 5);
        drain("bp_drain", 3);

        // flush of entries younger than branch tag 1
        rob_head = 3'd0;
        offer(FU_BCH, 3'd1, 16'hC001);
        offer(FU_ADD, 3'd3, 16'hC003);
        offer(FU_MUL, 3'd5, 16'hC005);
        expect_cdb(3'd1, 16'hC001);
        step();
        fu_valid = '0;
        flush = 1'b1;
        flush_tag = 3'd1;
        offer(FU_ADD, 3'd4, 16'hC004);
        step();
        flush = 1'b0;
        fu_valid = '0;
        chk("flush_tag1", cdb_tag, 1);
        step();
        chk("flush_idle", cdb_valid, 0);
        chk("flush_ready", fu_ready, 3'b111);
        drain("flush_drain", 3);

        // flush drops a killed incoming offer into an empty slot
        offer(FU_BCH, 3'd2, 16'hD002);
        expect_cdb(3'd2, 16'hD002);
        step();
        fu_valid = '0;
        flush = 1'b1;
        flush_tag = 3'd2;
        offer(FU_ADD, 3'd3, 16'hD003);
        #1 chk("flush_in_ready", fu_ready[0], 1);
        step();
        flush = 1'b0;
        fu_valid = '0;
        drain("flush_in_drain", 3);

        // streaming on mul
        rob_head = 3'd0;
        for (int i = 0; i < 8; i++) begin
            offer(FU_MUL, 3'(i), 16'h6000 + 16'(i));
            expect_cdb(3'(i), 16'h6000 + 16'(i));
            #1 chk("stream_ready", fu_ready[1], 1);
            step();
            if (i > 0) chk("stream_valid", cdb_valid, 1);
        end
        fu_valid = '0;
        step();
        chk("stream_last", cdb_valid, 1);
        chk("stream_last_tag", cdb_tag, 7);
        step();
        chk("stream_end", cdb_valid, 0);
        drain("stream_drain", 1);

        // reset mid-traffic
        rob_head = 3'd0;
        offer(FU_ADD, 3'd3, 16'hABCD);
        offer(FU_MUL, 3'd4, 16'hBCDE);
        offer(FU_BCH, 3'd5, 16'hCDEF);
        expect_cdb(3'd3, 16'hABCD);
        step();
        fu_valid = '0;
        step();
        chk("mid_before_rst", cdb_valid, 1);
        #6 rst = 1'b1;
        #1;
        chk("mid_rst_valid", cdb_valid, 0);
        chk("mid_rst_tag", cdb_tag, 0);
        chk("mid_rst_data", cdb_data, 0);
        chk("mid_rst_sb", sb.size(), 0);
        #1 rst = 1'b0;
        #1 chk("mid_rst_ready", fu_ready, 3'b111);
        drain("mid_rst_drain", 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Common-data-bus arbiter for the Tomasulo core.
- Add, mul and branch functional units each present a completed result (ROB tag + value). The block buffers one result per unit and broadcasts one result per cycle on the CDB, selecting the oldest by ROB age relative to the ROB head.
- Sits between the FU outputs and the CDB consumers: reservation stations, ROB and regbank tag clear.
- Supports branch-mispredict flush of results younger than the flushing branch.

Parameters:
- NUM_FU, 3, number of requesting functional units (0=add, 1=mul, 2=branch).
- ROB_DEPTH, 8, ROB entries; power of two.
- TAG_W, 3, ROB tag width; equals log2(ROB_DEPTH).
- DATA_W, 16, result width.

Ports:
- clk1  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- fu_valid  in  NUM_FU  per-FU result offer
- fu_ready  out  NUM_FU  per-FU accept; transfer when valid & ready at the clock edge
- fu_tag  in  NUM_FU*TAG_W  ROB tag of each offer; FU i uses bits [i*TAG_W +: TAG_W]
- fu_data  in  NUM_FU*DATA_W  result value of each offer
- rob_head  in  TAG_W  current ROB head pointer (oldest entry)
- flush  in  1  mispredict flush pulse
- flush_tag  in  TAG_W  ROB tag of the mispredicted branch
- cdb_valid  out  1  broadcast valid; registered
- cdb_tag  out  TAG_W  broadcast ROB tag; registered
- cdb_data  out  DATA_W  broadcast value; registered

Behaviour:
- Reset (async, rst=1):
  - all hold slots EMPTY;
  - cdb_valid=0, cdb_tag=0, cdb_data=0;
  - fu_ready=all ones as soon as rst deasserts (EMPTY slots).
  - Reset mid-operation discards every buffered and in-flight result.
- Per-FU hold slot, two states:
  - EMPTY -> FULL on fu_valid & fu_ready.
  - FULL -> EMPTY when granted, unless a new offer is accepted on the same edge; then it stays FULL with the new contents.
  - FULL -> EMPTY on flush when the slot's entry is younger than the branch.
- Ready rule: fu_ready[i] = slot EMPTY or slot granted this cycle. This permits one transfer per cycle per FU.
- Age: age(t) = (t - rob_head) mod ROB_DEPTH, using TAG_W-bit wrap subtraction; smaller age = older.
- Grant:
  - Each cycle, among FULL slots, the one with the smallest age wins.
  - Equal ages are illegal in operation; if they occur, the lowest FU index wins.
  - No FULL slot -> no grant.
- Broadcast: on each edge, cdb_valid <= grant_any; cdb_tag/cdb_data <= winner contents. cdb_tag/cdb_data hold their value when cdb_valid=0.
- Latency: offer accepted at edge k -> earliest cdb_valid in the cycle after edge k+1. Throughput is 1 broadcast/cycle.
- Flush (flush=1 at edge, fa = age(flush_tag)):
  - FULL slots with age > fa -> EMPTY; no broadcast.
  - A winner with age > fa is not broadcast; cdb_valid <= 0 unless an older slot exists. Among survivors the oldest wins the same edge.
  - Incoming offers with age > fa are accepted (ready unchanged) and dropped.
  - Entries with age <= fa, including the branch itself, are unaffected.
- Simultaneous offer + grant on the same FU: the old entry broadcasts and the new entry is stored.
- rob_head may change on any cycle; ages are recomputed combinationally every cycle.

Decomposition:
- Shared tomasulo_pkg holds:
  - ROB_DEPTH, TAG_W, DATA_W;
  - FU index constants FU_ADD=0, FU_MUL=1, FU_BCH=2;
  - an age(tag, head) function reused by the issue and commit logic.
- Sub-module cdb_hold_slot: one instance per FU, containing the EMPTY/FULL register, tag/data storage, ready generation and flush kill.
- Oldest-select logic and CDB output registers live in the top level.

Test Plan:
1. Reset mid-traffic: three slots FULL, rst pulsed asynchronously between edges -> cdb_valid=0, cdb_tag=0, cdb_data=0 immediately; fu_ready=3'b111 after release.
2. Single offer: head=0, add offers tag 2 data 0x1234 at edge 1 -> after edge 2 cdb_valid=1, cdb_tag=2, cdb_data=0x1234; after edge 3 cdb_valid=0.
3. Age with wrap: head=6; add tag 1, mul tag 7, bch tag 6 offered at the same edge -> broadcasts in consecutive cycles with tags 6, 7, 1, then cdb_valid=0.
4. Backpressure:
   - head=0; bch tag 1 and add tag 4 offered at the same edge.
   - Next cycle add offers tag 5 -> fu_ready[0]=0 while tag 1 broadcasts.
   - Tag 4 broadcasts next with fu_ready[0]=1; tag 5 is accepted on that edge and broadcast one cycle later.
5. Flush:
   - head=0; slots hold bch tag 1, add tag 3, mul tag 5.
   - flush=1, flush_tag=1, plus a concurrent add offer with tag 4 -> only tag 1 broadcast; tags 3, 4, 5 never appear on the CDB.
6. Streaming: mul is the sole requester, offering tags 0..7 on consecutive edges with head=0 -> cdb_valid is high for 8 consecutive cycles starting after edge 2, tags 0..7 in order, fu_ready[1]=1 throughout.
